// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control FSM
// Holds the FSM state encoding, the instruction class produced by the decoder,
// and the opcode, aluOp and pcSrc codes used by the controller.
package mips_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, EXWAIT, MEM, WB, BRANCH, HALT} stateT;
    typedef enum logic [2:0] {CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_JMP, CLS_ILL} classT;
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ANDI = 4'd2;
    localparam logic [3:0] OP_ORI = 4'd3;
    localparam logic [3:0] OP_SLTI = 4'd4;
    localparam logic [3:0] OP_LW = 4'd5;
    localparam logic [3:0] OP_SW = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_J = 4'd8;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the FSM and the datapath + memories
// master: the controller (takes instr/zero/acks, drives every enable and select)
// slave:  the datapath/memory side
interface multicycle_control_if;
    logic [15:0] instr;
    logic zero;
    logic imemAck;
    logic dmemAck;
    logic imemReq;
    logic dmemReq;
    logic dmemWe;
    logic irWrite;
    logic pcWrite;
    logic [1:0] pcSrc;
    logic aluSrc;
    logic [2:0] aluOp;
    logic regDst;
    logic memToReg;
    logic regWrite;
    logic illegal;
    logic busError;
    modport master (
        input instr, zero, imemAck, dmemAck,
        output imemReq, dmemReq, dmemWe, irWrite, pcWrite, pcSrc, aluSrc, aluOp,
        output regDst, memToReg, regWrite, illegal, busError
    );
    modport slave (
        output instr, zero, imemAck, dmemAck,
        input imemReq, dmemReq, dmemWe, irWrite, pcWrite, pcSrc, aluSrc, aluOp,
        input regDst, memToReg, regWrite, illegal, busError
    );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational opcode decoder for the multi-cycle controller
// opcode in 4: instr[15:12]; aluSrc/aluOp: execute selects; regDst/memToReg: write-back
// selects; cls: instruction class steering the FSM (alu/ld/st/br/jmp/illegal).
module control_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       aluSrc,
    output logic [2:0] aluOp,
    output logic       regDst,
    output logic       memToReg,
    output classT      cls
);
    always_comb begin
        aluSrc = 1'b1;
        aluOp = ALU_ADD;
        regDst = 1'b0;
        memToReg = 1'b0;
        cls = CLS_ALU;
        case (opcode)
            OP_RTYPE: begin
                aluSrc = 1'b0;
                aluOp = ALU_FUNCT;
                regDst = 1'b1;
            end
            OP_ADDI: ;
            OP_ANDI: aluOp = ALU_AND;
            OP_ORI: aluOp = ALU_OR;
            OP_SLTI: aluOp = ALU_SLT;
            OP_LW: begin
                memToReg = 1'b1;
                cls = CLS_LD;
            end
            OP_SW: cls = CLS_ST;
            OP_BEQ: begin
                aluSrc = 1'b0;
                aluOp = ALU_SUB;
                cls = CLS_BR;
            end
            OP_J: begin
                aluSrc = 1'b0;
                cls = CLS_JMP;
            end
            default: begin
                aluSrc = 1'b0;
                cls = CLS_ILL;
            end
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the 16-bit multi-cycle MIPS datapath
// clk/reset: rising-edge clock, synchronous active-high reset.
// bus (master): instr/zero/imemAck/dmemAck in; memory requests, IR/PC/regfile enables,
// ALU selects and the sticky illegal/busError flags out.
// MEM_TIMEOUT: request cycles allowed without an ack before faulting into HALT.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input logic clk,
    input logic reset,
    multicycle_control_if.master bus
);
    stateT state, nextState;
    logic [3:0] opcodeQ;
    logic [7:0] cnt;
    logic imemReq, dmemReq, dmemWe, aluSrc, regDst, memToReg, regWrite, illegal, busError;
    logic [2:0] aluOp;
    classT cls;
    logic dAluSrc, dRegDst, dMemToReg;
    logic [2:0] dAluOp;
    logic [3:0] decOp;
    logic imemHit, dmemHit, waiting, timeout, holdAlu, jmpNow, brTake;
    logic unusedInstr;
    assign unusedInstr = ^bus.instr[11:0];
    // The IR already holds the new word during DECODE, so decode it live there;
    // every later state works from the copy latched at the end of DECODE.
    assign decOp = (state == DECODE) ? bus.instr[15:12] : opcodeQ;
    control_decode dec (
        .opcode(decOp),
        .aluSrc(dAluSrc),
        .aluOp(dAluOp),
        .regDst(dRegDst),
        .memToReg(dMemToReg),
        .cls(cls)
    );
    // Acks only count against a request that is actually up.
    assign imemHit = imemReq && bus.imemAck;
    assign dmemHit = dmemReq && bus.dmemAck;
    assign waiting = (imemReq && !bus.imemAck) || (dmemReq && !bus.dmemAck);
    // cnt holds the request cycles already spent; this cycle would make it MEM_TIMEOUT.
    assign timeout = waiting && (({1'b0, cnt} + 9'd1) == 9'(MEM_TIMEOUT));
    assign holdAlu = nextState inside {EXEC, EXWAIT, MEM, WB, BRANCH};
    assign jmpNow = (state == DECODE) && (cls == CLS_JMP);
    assign brTake = (state == BRANCH) && bus.zero;
    always_comb begin
        nextState = state;
        case (state)
            FETCH: nextState = imemHit ? DECODE : timeout ? HALT : FETCH;
            DECODE: nextState = (cls == CLS_JMP || cls == CLS_ILL) ? FETCH : EXEC;
            EXEC: nextState = (cls == CLS_BR) ? BRANCH : EXWAIT;
            EXWAIT: nextState = (cls == CLS_BR) ? BRANCH : (cls == CLS_LD || cls == CLS_ST) ? MEM : WB;
            MEM: nextState = dmemHit ? ((cls == CLS_ST) ? FETCH : WB) : timeout ? HALT : MEM;
            WB: nextState = FETCH;
            BRANCH: nextState = FETCH;
            HALT: nextState = HALT;
        endcase
    end
    // Moore outputs are registered from the next state; right after reset the FSM
    // spends one cycle in FETCH with the request still low so nothing moves while
    // reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            opcodeQ <= '0;
            cnt <= '0;
            imemReq <= 1'b0;
            dmemReq <= 1'b0;
            dmemWe <= 1'b0;
            aluSrc <= 1'b0;
            aluOp <= ALU_ADD;
            regDst <= 1'b0;
            memToReg <= 1'b0;
            regWrite <= 1'b0;
            illegal <= 1'b0;
            busError <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= (nextState != state) ? 8'd0 : cnt + 8'(imemReq | dmemReq);
            if (state == DECODE) opcodeQ <= bus.instr[15:12];
            imemReq <= nextState == FETCH;
            dmemReq <= nextState == MEM;
            dmemWe <= nextState == MEM && cls == CLS_ST;
            aluSrc <= holdAlu && dAluSrc;
            aluOp <= holdAlu ? dAluOp : ALU_ADD;
            regDst <= nextState == WB && dRegDst;
            memToReg <= nextState == WB && dMemToReg;
            regWrite <= nextState == WB;
            illegal <= illegal || (state == DECODE && cls == CLS_ILL);
            busError <= busError || timeout;
        end
    end
    assign bus.imemReq = imemReq;
    assign bus.dmemReq = dmemReq;
    assign bus.dmemWe = dmemWe;
    assign bus.irWrite = imemHit;
    assign bus.pcWrite = imemHit || jmpNow || brTake;
    assign bus.pcSrc = jmpNow ? PC_JUMP : brTake ? PC_BRANCH : PC_SEQ;
    assign bus.aluSrc = aluSrc;
    assign bus.aluOp = aluOp;
    assign bus.regDst = regDst;
    assign bus.memToReg = memToReg;
    assign bus.regWrite = regWrite;
    assign bus.illegal = illegal;
    assign bus.busError = busError;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for multicycle_control (MEM_TIMEOUT = 4)
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    multicycle_control_if bus ();
    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic waitFetch(input string tag);
        for (int i = 0; i < 6 && bus.imemReq !== 1'b1; i++) cyc();
        check({tag, ".fetchReq"}, 32'(bus.imemReq), 1);
    endtask

    // Entered in the FETCH cycle; leaves one cycle into DECODE with the ack dropped.
    task automatic fetch(input string tag, input logic [15:0] ins);
        bus.instr = ins;
        bus.imemAck = 1'b1;
        #1;
        check({tag, ".irWrite"}, 32'(bus.irWrite), 1);
        check({tag, ".pcWriteF"}, 32'(bus.pcWrite), 1);
        check({tag, ".pcSrcF"}, 32'(bus.pcSrc), 0);
        cyc();
        bus.imemAck = 1'b0;
        #1;
        check({tag, ".reqLow"}, 32'(bus.imemReq), 0);
    endtask

    task automatic runAlu(input string tag, input logic [15:0] ins, input logic [31:0] src,
                          input logic [31:0] op, input logic [31:0] dst);
        fetch(tag, ins);
        check({tag, ".pcWriteD"}, 32'(bus.pcWrite), 0);
        for (int c = 3; c <= 4; c++) begin
            cyc();
            check({tag, ".aluSrc"}, 32'(bus.aluSrc), src);
            check({tag, ".aluOp"}, 32'(bus.aluOp), op);
            check({tag, ".noWb"}, 32'(bus.regWrite), 0);
        end
        cyc();
        check({tag, ".regWrite"}, 32'(bus.regWrite), 1);
        check({tag, ".regDst"}, 32'(bus.regDst), dst);
        check({tag, ".memToReg"}, 32'(bus.memToReg), 0);
        check({tag, ".aluOpHeld"}, 32'(bus.aluOp), op);
        cyc();
        check({tag, ".refetch"}, 32'(bus.imemReq), 1);
        check({tag, ".wbDone"}, 32'(bus.regWrite), 0);
    endtask

    task automatic runBeq(input string tag, input logic z);
        fetch(tag, 16'h7012);
        cyc();
        bus.zero = 1'b1;
        #1;
        check({tag, ".aluSrc"}, 32'(bus.aluSrc), 0);
        check({tag, ".aluOp"}, 32'(bus.aluOp), 1);
        check({tag, ".execNoPc"}, 32'(bus.pcWrite), 0);
        cyc();
        bus.zero = z;
        #1;
        check({tag, ".pcWrite"}, 32'(bus.pcWrite), 32'(z));
        check({tag, ".pcSrc"}, 32'(bus.pcSrc), z ? 1 : 0);
        cyc();
        bus.zero = 1'b0;
        #1;
        check({tag, ".refetch"}, 32'(bus.imemReq), 1);
    endtask

    initial begin
        bus.instr = 16'h0000;
        bus.zero = 1'b0;
        bus.imemAck = 1'b0;
        bus.dmemAck = 1'b0;
        repeat (3) cyc();
        check("rst.imemReq", 32'(bus.imemReq), 0);
        check("rst.dmemReq", 32'(bus.dmemReq), 0);
        check("rst.pcWrite", 32'(bus.pcWrite), 0);
        check("rst.regWrite", 32'(bus.regWrite), 0);
        check("rst.aluOp", 32'(bus.aluOp), 0);
        check("rst.illegal", 32'(bus.illegal), 0);
        check("rst.busError", 32'(bus.busError), 0);
        reset = 1'b0;
        waitFetch("start");
        runAlu("rtype", 16'h0123, 0, 3'b010, 1);
        runAlu("addi", 16'h1234, 1, 3'b000, 0);
        runAlu("andi", 16'h2345, 1, 3'b011, 0);
        runAlu("ori", 16'h3456, 1, 3'b100, 0);
        runAlu("slti", 16'h4567, 1, 3'b101, 0);
        // lw, data ack on the 4th request cycle: counter reaches MEM_TIMEOUT with the ack
        fetch("lw", 16'h5004);
        cyc();
        check("lw.aluSrc", 32'(bus.aluSrc), 1);
        check("lw.aluOp", 32'(bus.aluOp), 0);
        cyc();
        check("lw.noReqYet", 32'(bus.dmemReq), 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.dmemAck = (k == 3);
            #1;
            check("lw.dmemReq", 32'(bus.dmemReq), 1);
            check("lw.dmemWe", 32'(bus.dmemWe), 0);
        end
        cyc();
        bus.dmemAck = 1'b0;
        #1;
        check("lw.reqDone", 32'(bus.dmemReq), 0);
        check("lw.regWrite", 32'(bus.regWrite), 1);
        check("lw.memToReg", 32'(bus.memToReg), 1);
        check("lw.regDst", 32'(bus.regDst), 0);
        check("lw.noBusErr", 32'(bus.busError), 0);
        cyc();
        check("lw.refetch", 32'(bus.imemReq), 1);
        runBeq("beqTaken", 1'b1);
        runBeq("beqNot", 1'b0);
        fetch("j", 16'h8abc);
        check("j.pcWrite", 32'(bus.pcWrite), 1);
        check("j.pcSrc", 32'(bus.pcSrc), 2);
        cyc();
        check("j.refetch", 32'(bus.imemReq), 1);
        fetch("ill", 16'hF000);
        check("ill.beforeEdge", 32'(bus.illegal), 0);
        check("ill.noPc", 32'(bus.pcWrite), 0);
        cyc();
        check("ill.flag", 32'(bus.illegal), 1);
        check("ill.refetch", 32'(bus.imemReq), 1);
        check("ill.noWb", 32'(bus.regWrite), 0);
        runAlu("afterIll", 16'h1000, 1, 3'b000, 0);
        check("ill.sticky", 32'(bus.illegal), 1);
        // sw with an immediate data ack
        fetch("sw", 16'h6010);
        cyc();
        cyc();
        cyc();
        bus.dmemAck = 1'b1;
        #1;
        check("sw.dmemReq", 32'(bus.dmemReq), 1);
        check("sw.dmemWe", 32'(bus.dmemWe), 1);
        cyc();
        bus.dmemAck = 1'b0;
        #1;
        check("sw.reqDone", 32'(bus.dmemReq), 0);
        check("sw.noWb", 32'(bus.regWrite), 0);
        check("sw.refetch", 32'(bus.imemReq), 1);
        // sw abandoned by reset in the middle of its data wait
        fetch("swRst", 16'h6020);
        cyc();
        cyc();
        cyc();
        check("swRst.dmemReq", 32'(bus.dmemReq), 1);
        cyc();
        check("swRst.dmemWe", 32'(bus.dmemWe), 1);
        reset = 1'b1;
        cyc();
        check("swRst.reqDrop", 32'(bus.dmemReq), 0);
        check("swRst.weDrop", 32'(bus.dmemWe), 0);
        check("swRst.illClr", 32'(bus.illegal), 0);
        reset = 1'b0;
        waitFetch("swRst");
        // instruction fetch never acked: fault after 4 request cycles
        bus.instr = 16'h0123;
        for (int k = 0; k < 4; k++) begin
            check("to.imemReq", 32'(bus.imemReq), 1);
            check("to.noErrYet", 32'(bus.busError), 0);
            cyc();
        end
        check("to.busError", 32'(bus.busError), 1);
        check("to.haltReq", 32'(bus.imemReq), 0);
        bus.imemAck = 1'b1;
        #1;
        check("halt.ackIgnored", 32'(bus.irWrite), 0);
        check("halt.pcWrite", 32'(bus.pcWrite), 0);
        repeat (3) cyc();
        check("halt.stays", 32'(bus.imemReq), 0);
        check("halt.sticky", 32'(bus.busError), 1);
        check("halt.regWrite", 32'(bus.regWrite), 0);
        bus.imemAck = 1'b0;
        reset = 1'b1;
        cyc();
        check("rec.busErrClr", 32'(bus.busError), 0);
        reset = 1'b0;
        waitFetch("rec");
        runAlu("recAlu", 16'h0456, 0, 3'b010, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing FSM for the 16-bit multi-cycle MIPS datapath. It fetches each instruction through an ack-based instruction-memory handshake and decodes the opcode. It then drives the execute stage's `aluSrc`/`aluOp` selects, waits out the registered ALU result, and performs data-memory access and register write-back. It sits beside the datapath and owns every enable and select the datapath uses.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15: maximum cycles to wait for any memory ack before faulting (range 1–255).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `instr` in 16: instruction register contents from the datapath; `instr[15:12]` is the opcode.
- `zero` in 1: ALU zero flag.
- `imemAck` in 1: instruction word valid this cycle.
- `dmemAck` in 1: data access complete this cycle.
- `imemReq` out 1: instruction fetch request.
- `dmemReq` out 1: data access request.
- `dmemWe` out 1: data write (valid with `dmemReq`).
- `irWrite` out 1: load the instruction register.
- `pcWrite` out 1: update the PC.
- `pcSrc` out 2: 00 = PC+1, 01 = branch target, 10 = jump target.
- `aluSrc` out 1: 0 = `readData2`, 1 = immediate.
- `aluOp` out 3: ALU operation class.
- `regDst` out 1: 1 = rd, 0 = rt.
- `memToReg` out 1: write-back source is memory.
- `regWrite` out 1: register file write enable.
- `illegal` out 1: sticky; an undefined opcode was seen.
- `busError` out 1: sticky; a memory timeout occurred.

## Operation
- States: FETCH, DECODE, EXEC, EXWAIT, MEM, WB, BRANCH, HALT.
- Opcodes:
  - 0 R-type; 1 addi; 2 andi; 3 ori; 4 slti; 5 lw; 6 sw; 7 beq; 8 j.
  - 9–15 are illegal.
- `aluOp` codes: 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 slt.
- FETCH:
  - Assert `imemReq`.
  - On `imemAck`: `irWrite`=1, `pcWrite`=1, `pcSrc`=00, then go to DECODE.
- DECODE:
  - Opcode latched internally.
  - j: `pcWrite`=1, `pcSrc`=10, then go to FETCH.
  - Illegal opcode: set `illegal`, then go to FETCH.
  - Otherwise go to EXEC.
- EXEC: drive `aluSrc`/`aluOp` per opcode.
  - R-type: 0/010.
  - addi, lw, sw: 1/000.
  - andi: 1/011.
  - ori: 1/100.
  - slti: 1/101.
  - beq: 0/001.
- EXWAIT:
  - Hold the EXEC selects for one more cycle; the ALU output is registered.
  - Next state: beq goes to BRANCH; lw and sw go to MEM; all others go to WB.
- BRANCH: if `zero`, `pcWrite`=1 and `pcSrc`=01. Then go to FETCH.
- MEM:
  - Assert `dmemReq`; `dmemWe`=1 for sw.
  - On `dmemAck`: sw goes to FETCH, lw goes to WB.
- WB:
  - `regWrite`=1.
  - `regDst`=1 for R-type, else 0.
  - `memToReg`=1 for lw.
  - Then go to FETCH.
- Timeout counter (8 bits):
  - Clears on entry to FETCH or MEM and increments each waiting cycle.
  - Reaching `MEM_TIMEOUT` with no ack: set `busError`, go to HALT.
- HALT: all outputs 0 except the sticky flags. It is left only by `reset`.
- Outputs not listed for a state are 0.
- `aluSrc`/`aluOp` are held from EXEC through WB, so the ALU result stays stable while it is consumed.

## Timing
- Reset:
  - FSM enters FETCH on the cycle after `reset` is sampled high.
  - All outputs are 0 during reset, including `illegal`, `busError` and the counter.
  - Reset mid-MEM drops `dmemReq` at the same edge; the write is abandoned.
- Request/ack rules:
  - `imemReq`/`dmemReq` are high for the whole wait.
  - An ack is accepted on the edge where the request is high. An ack in the first cycle counts.
  - The request is low the cycle after an ack.
  - An ack while no request is pending is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - R-type/I-type ALU: 5 cycles.
  - lw: 6. sw: 5. beq: 4. j: 2. Illegal: 2.
- An ack on the same cycle the counter reaches `MEM_TIMEOUT` is accepted; no error is raised.
- `zero` is sampled only in BRANCH.
- Flags do not stall the FSM except when entering HALT.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state encoding (3-bit);
  - opcode constants;
  - `aluOp` constants;
  - `pcSrc` constants.
- Sub-module `control_decode` is combinational: opcode to {`aluSrc`, `aluOp`, `regDst`, `memToReg`, class: alu/ld/st/br/jmp/illegal}. The FSM instantiates it on the latched opcode.

## Test plan
- Reset, then `instr`=0x0123 (R-type) with immediate acks → `imemReq` at cycle 1; `aluSrc`=0 and `aluOp`=010 in cycles 3–4; `regWrite`=1 and `regDst`=1 in cycle 5; FETCH again in cycle 6.
- lw 0x5xxx with `dmemAck` delayed 3 cycles → `dmemReq` high for exactly 4 cycles with `dmemWe`=0; then WB with `memToReg`=1; total 9 cycles.
- beq 0x7xxx run twice, `zero`=1 then `zero`=0 → first: `pcWrite`=1, `pcSrc`=01 in cycle 4; second: no `pcWrite` in BRANCH.
- Opcode 0xF → `illegal` rises at the DECODE edge and stays high; the next fetch proceeds; no `regWrite`.
- `MEM_TIMEOUT`=4 and `imemAck` never asserted → `busError` set after 4 request cycles, HALT with all outputs 0; `reset` returns to FETCH with the flags cleared.
- `reset` asserted during sw MEM wait → `dmemReq`/`dmemWe` low on the next cycle and FSM in FETCH.
